cgra_obi_arbiter: RTL

//  Shares the single CGRA interface OBI master port between NUM_REQ CGRA-side requesters (column load/store units).

---
 rtl/cgra_arb_pkg.sv | 18 +
 rtl/cgra_arb_id_fifo.sv | 59 +++++
 rtl/cgra_obi_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cgra_arb_pkg.sv
// rtl/cgra_arb_pkg.sv - shared constants, types and helpers for the CGRA OBI arbiter
package cgra_arb_pkg;

  // Default configuration of the CGRA interface master port
  localparam int ARB_NUM_REQ         = 4;
  localparam int ARB_MAX_OUTSTANDING = 4;

  localparam int IDX_W = $clog2(ARB_NUM_REQ);
  localparam int CNT_W = $clog2(ARB_MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] req_idx_t;

  // Increment an index modulo n (n need not be a power of two)
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cgra_arb_id_fifo.sv
// rtl/cgra_arb_id_fifo.sv - in-flight requester ID FIFO with fall-through head
module cgra_arb_id_fifo
  import cgra_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int CNT_BITS = $clog2(DEPTH + 1),
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_BITS-1:0] count_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pops on empty are ignored; a push on full is only accepted alongside a pop
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array, written at the tail
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
      if (do_pop)  rd_ptr_q <= PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cgra_obi_arbiter.sv
// rtl/cgra_obi_arbiter.sv - round-robin OBI arbiter sharing the CGRA master port
module cgra_obi_arbiter
  import cgra_arb_pkg::*;
#(
  parameter int NUM_REQ         = ARB_NUM_REQ,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  localparam int BE_W  = DATA_WIDTH / 8,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]           we_i,
  input  logic [NUM_REQ*BE_W-1:0]      be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           rvalid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic                         m_req_o,
  output logic [ADDR_WIDTH-1:0]        m_addr_o,
  output logic                         m_we_o,
  output logic [BE_W-1:0]              m_be_o,
  output logic [DATA_WIDTH-1:0]        m_wdata_o,
  input  logic                         m_gnt_i,
  input  logic                         m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        m_rdata_i,
  output logic [OUT_W-1:0]             outstanding_o,
  output logic                         err_o
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] lock_idx_q;
  logic             lock_q;
  logic             err_q;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;
  logic             resp_ok;

  assign m_req_o = (lock_q | (|req_i)) & ~fifo_full;
  assign hs      = m_req_o & m_gnt_i;
  assign resp_ok = m_rvalid_i & ~fifo_empty;
  assign rdata_o = m_rdata_i;
  assign err_o   = err_q;

  // Round-robin scan starting at rr_ptr_q; a stalled request stays locked to its owner
  always_comb begin
    int  j;
    logic found;
    sel   = rr_ptr_q;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        sel   = SEL_W'(j);
        found = 1'b1;
      end
    end
    if (lock_q) sel = lock_idx_q;
  end

  // Master-side request mux; everything reads zero when no request is presented
  always_comb begin
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    if (m_req_o) begin
      m_addr_o  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      m_we_o    = we_i[sel];
      m_be_o    = be_i[int'(sel)*BE_W +: BE_W];
      m_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant pass-through and response routing to the oldest in-flight requester
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)      gnt_o[sel]     = 1'b1;
    if (resp_ok) rvalid_o[head] = 1'b1;
  end

  // Pointer, lock and sticky error state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr_q <= SEL_W'(wrap_inc(int'(sel), NUM_REQ));
        lock_q   <= 1'b0;
      end else if (m_req_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (m_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  cgra_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (SEL_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .wdata_i (sel),
    .pop_i   (resp_ok),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule
